// File: rtl/program_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte frame into 32-bit words,
// writes them to instruction memory, then releases core reset. Optional trailer check: LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int          ADDR_WIDTH = 8,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_reset,
  output logic                  load_done,
  output logic                  load_error,
  output logic [ADDR_WIDTH:0]   words_loaded
);

  localparam logic [ADDR_WIDTH-1:0] START_A = ADDR_WIDTH'(START_ADDR);
  localparam logic [31:0]           DEPTH   = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_HDR0  = 3'd0,
    S_HDR1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    S_ERROR = 3'd5,
    S_CHK   = 3'd6
`else
    S_ERROR = 3'd5
`endif
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [15:0]           r_n;
  logic [1:0]            r_byte_cnt;
  logic [31:0]           r_word;
  logic [ADDR_WIDTH:0]   r_words_loaded;
  logic                  r_rx_ready;
  logic                  r_imem_we;
  logic [ADDR_WIDTH-1:0] r_imem_addr;
  logic [31:0]           r_imem_wdata;
  logic                  r_core_reset;
  logic                  r_load_done;
  logic                  r_load_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic        w_accept;
  logic [15:0] w_n_full;
  logic        w_more;
  state_t      w_end;

  assign w_accept = rx_valid && r_rx_ready;
  assign w_n_full = {rx_data, r_n[7:0]};
  assign w_more   = (32'(r_words_loaded) + 32'd1) < {16'd0, r_n};
`ifdef LOADER_CHECKSUM_EN
  assign w_end    = S_CHK;
`else
  assign w_end    = S_DONE;
`endif

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state <= S_HDR0;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_HDR0: begin
        if (w_accept) w_next = S_HDR1;
        else          w_next = r_state;
      end
      S_HDR1: begin
        if (!w_accept)                         w_next = r_state;
        else if ({16'd0, w_n_full} > DEPTH)    w_next = S_ERROR;
        else if (w_n_full == 16'd0)            w_next = w_end;
        else                                   w_next = S_DATA;
      end
      S_DATA: begin
        if (w_accept && (r_byte_cnt == 2'd3)) w_next = S_WRITE;
        else                                  w_next = r_state;
      end
      S_WRITE: begin
        if (w_more) w_next = S_DATA;
        else        w_next = w_end;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (!w_accept)              w_next = r_state;
        else if (rx_data == r_csum) w_next = S_DONE;
        else                        w_next = S_ERROR;
      end
`endif
      S_DONE:  w_next = S_DONE;
      S_ERROR: w_next = S_ERROR;
      default: w_next = S_HDR0;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk) begin
    if (areset) begin
      r_n            <= 16'd0;
      r_byte_cnt     <= 2'd0;
      r_word         <= 32'd0;
      r_words_loaded <= '0;
      r_rx_ready     <= 1'b1;
      r_imem_we      <= 1'b0;
      r_imem_addr    <= START_A;
      r_imem_wdata   <= 32'd0;
      r_core_reset   <= 1'b1;
      r_load_done    <= 1'b0;
      r_load_error   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum         <= 8'd0;
`endif
    end else begin
`ifdef LOADER_CHECKSUM_EN
      r_rx_ready   <= (w_next == S_HDR0) || (w_next == S_HDR1) ||
                      (w_next == S_DATA) || (w_next == S_CHK);
      if (w_accept && (r_state != S_CHK)) r_csum <= r_csum ^ rx_data;
`else
      r_rx_ready   <= (w_next == S_HDR0) || (w_next == S_HDR1) || (w_next == S_DATA);
`endif
      r_imem_we    <= (w_next == S_WRITE);
      r_core_reset <= (w_next != S_DONE);
      r_load_done  <= (w_next == S_DONE);
      r_load_error <= (w_next == S_ERROR);
      if (w_accept && (r_state == S_HDR0)) r_n[7:0]  <= rx_data;
      if (w_accept && (r_state == S_HDR1)) r_n[15:8] <= rx_data;
      if (w_accept && (r_state == S_DATA)) begin
        r_word[{r_byte_cnt, 3'b000} +: 8] <= rx_data;
        r_byte_cnt                        <= r_byte_cnt + 2'd1;
      end
      // The final byte bypasses the assembly register straight into the write data
      if ((r_state == S_DATA) && (w_next == S_WRITE)) begin
        r_imem_wdata <= {rx_data, r_word[23:0]};
        r_imem_addr  <= START_A + r_words_loaded[ADDR_WIDTH-1:0];
      end
      if (r_state == S_WRITE) r_words_loaded <= r_words_loaded + 1'b1;
    end
  end

  assign rx_ready     = r_rx_ready;
  assign imem_we      = r_imem_we;
  assign imem_addr    = r_imem_addr;
  assign imem_wdata   = r_imem_wdata;
  assign core_reset   = r_core_reset;
  assign load_done    = r_load_done;
  assign load_error   = r_load_error;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_program_loader.sv
// Randomized directed bench: two loader instances (depth 256 @0, depth 4 @3) share one byte stream.
module tb_program_loader;
  logic       clk = 1'b0;
  logic       areset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'd0;

  logic rdy1, we1, cr1, ld1, le1;
  logic [7:0]  addr1;
  logic [31:0] wd1;
  logic [8:0]  wl1;
  logic rdy2, we2, cr2, ld2, le2;
  logic [1:0]  addr2;
  logic [31:0] wd2;
  logic [2:0]  wl2;

  program_loader #(.ADDR_WIDTH(8), .START_ADDR(0)) dut (
    .clk(clk), .areset(areset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rdy1),
    .imem_we(we1), .imem_addr(addr1), .imem_wdata(wd1), .core_reset(cr1),
    .load_done(ld1), .load_error(le1), .words_loaded(wl1));

  program_loader #(.ADDR_WIDTH(2), .START_ADDR(3)) dut2 (
    .clk(clk), .areset(areset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rdy2),
    .imem_we(we2), .imem_addr(addr2), .imem_wdata(wd2), .core_reset(cr2),
    .load_done(ld2), .load_error(le2), .words_loaded(wl2));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we = -1;
  int done_cyc = -1;
  logic [39:0] wq1[$];
  logic [39:0] wq2[$];
  logic [7:0]  dat[$];

  // Write monitor: captures every memory write of both instances
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (areset) begin
      wq1.delete();
      wq2.delete();
      last_we  <= -1;
      done_cyc <= -1;
    end else begin
      if (we1) begin
        wq1.push_back({addr1, wd1});
        last_we <= cyc;
      end
      if (we2) wq2.push_back({6'd0, addr2, wd2});
      if (ld1 && (done_cyc < 0)) done_cyc <= cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset = 1'b1;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic check_reset();
    check("rst_rdy1", rdy1, 1); check("rst_we1", we1, 0); check("rst_addr1", addr1, 0);
    check("rst_wd1", wd1, 0); check("rst_cr1", cr1, 1); check("rst_ld1", ld1, 0);
    check("rst_le1", le1, 0); check("rst_wl1", wl1, 0);
    check("rst_addr2", addr2, 3); check("rst_we2", we2, 0); check("rst_cr2", cr2, 1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!rdy1 && (t < 40)) begin
      @(negedge clk);
      t++;
    end
    check("handshake_ready", rdy1, 1);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic gap(input int n);
    if (n > 0) begin
      rx_valid = 1'b0;
      repeat (n) @(negedge clk);
    end
  endtask

  task automatic fill(input int n);
    dat.delete();
    for (int i = 0; i < 4 * n; i++) dat.push_back(8'($urandom_range(0, 255)));
  endtask

  // Reference: word i lands at (start+i) mod depth, bytes little-endian; oversized images write nothing
  task automatic compare_model(input int n);
    bit          e1, e2;
    int          sz;
    logic [31:0] w;
    e1 = (n > 256);
    e2 = (n > 4);
    check("ld1", ld1, !e1); check("le1", le1, e1); check("cr1", cr1, e1); check("rdy1_end", rdy1, 0);
    check("wl1", wl1, e1 ? 0 : n);
    check("nwrites1", wq1.size(), e1 ? 0 : n);
    sz = (wq1.size() < (e1 ? 0 : n)) ? wq1.size() : (e1 ? 0 : n);
    for (int i = 0; i < sz; i++) begin
      w = {dat[4*i+3], dat[4*i+2], dat[4*i+1], dat[4*i]};
      check("write1", wq1[i], {8'(i % 256), w});
    end
    check("ld2", ld2, !e2); check("le2", le2, e2); check("cr2", cr2, e2); check("rdy2_end", rdy2, 0);
    check("wl2", wl2, e2 ? 0 : n);
    check("nwrites2", wq2.size(), e2 ? 0 : n);
    sz = (wq2.size() < (e2 ? 0 : n)) ? wq2.size() : (e2 ? 0 : n);
    for (int i = 0; i < sz; i++) begin
      w = {dat[4*i+3], dat[4*i+2], dat[4*i+1], dat[4*i]};
      check("write2_wrap", wq2[i], {8'((3 + i) % 4), w});
    end
`ifndef LOADER_CHECKSUM_EN
    if (!e1 && (n > 0)) check("done_after_last_we", done_cyc, last_we + 1);
`endif
  endtask

  task automatic run_frame(input int n, input int gapmax, input bit do_rst);
    logic [7:0] fb[$];
    logic [7:0] cs;
    int         t;
    if (do_rst) begin
      do_reset();
      check_reset();
    end
    fb.push_back(n[7:0]);
    fb.push_back(n[15:8]);
    if (n <= 256) foreach (dat[i]) fb.push_back(dat[i]);
`ifdef LOADER_CHECKSUM_EN
    if (n <= 256) begin
      cs = 8'd0;
      foreach (fb[i]) cs = cs ^ fb[i];
      fb.push_back(cs);
    end
`endif
    foreach (fb[i]) begin
      gap($urandom_range(0, gapmax));
      send_byte(fb[i]);
    end
    rx_valid = 1'b0;
    t = 0;
    while (!(ld1 || le1) && (t < 50)) begin
      @(negedge clk);
      t++;
    end
    check("frame_settled", ld1 | le1, 1);
`ifndef LOADER_CHECKSUM_EN
    if (n == 0) check("n0_done_latency", t, 0);
`endif
    @(negedge clk);
    #1;
    compare_model(n);
  endtask

  initial begin
    logic [7:0] tp[$];
    repeat (2) @(negedge clk);
    tp = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    dat = tp;
    run_frame(2, 0, 1'b1);
    check("tp_word0", wq1.size() > 0 ? wq1[0] : 40'd0, {8'h00, 32'h00000013});
    check("tp_word1", wq1.size() > 1 ? wq1[1] : 40'd0, {8'h01, 32'h00100093});
    dat = tp;
    run_frame(2, 3, 1'b1);
    dat.delete();
    run_frame(0, 3, 1'b1);
    dat.delete();
    run_frame(257, 0, 1'b1);
    fill(4);
    run_frame(4, 2, 1'b1);

    do_reset();
    check_reset();
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)));
    do_reset();
    check_reset();
    fill(1);
    run_frame(1, 1, 1'b0);

    for (int k = 0; k < 3; k++) begin
      fill(int'($urandom_range(1, 6)));
      run_frame(dat.size() / 4, 3, 1'b1);
    end

`ifdef LOADER_CHECKSUM_EN
    tp = {8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
    do_reset();
    foreach (tp[i]) send_byte(tp[i]);
    send_byte(8'h12);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("csum_ok_done", ld1, 1); check("csum_ok_err", le1, 0); check("csum_ok_cr", cr1, 0);
    do_reset();
    foreach (tp[i]) send_byte(tp[i]);
    send_byte(8'h00);
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("csum_bad_err", le1, 1); check("csum_bad_cr", cr1, 1); check("csum_bad_done", ld1, 0);
    check("csum_bad_kept_write", wq1.size(), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
